// File: rtl/vliw_fetch.sv
// Instruction fetch with a bundle FIFO feeding a registered two-slot output.
// Define VLIW_FETCH_BYPASS_EN to let a response into an empty buffer reach the output on the same edge.
module vliw_fetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [63:0] imem_rdata,
  output logic [31:0] ixu_inst,
  output logic [31:0] slot1_inst,
  output logic [31:0] bundle_pc,
  output logic        bundle_valid,
  output logic [1:0]  fetch_state
);

  // imem handshake: imem_req stays high with imem_addr stable until one
  // imem_valid cycle returns that bundle; only one request is ever open.

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]    state, state_next;
  logic [31:0]   pc;
  logic [31:0]   pc_mem   [DEPTH];
  logic [63:0]   data_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          accept, byp, push, pop;

  always_comb begin
    accept = (state == BUSY) && imem_valid && !redirect;
`ifdef VLIW_FETCH_BYPASS_EN
    byp = accept && (count == '0) && !stall;
`else
    byp = 1'b0;
`endif
    push = accept && !byp;
    pop  = !stall && !redirect && (count != '0);
    count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!redirect && (count_next < FULL)) state_next = BUSY;
      BUSY: begin
        if (redirect)        state_next = imem_valid ? IDLE : DROP;
        else if (imem_valid) state_next = (count_next < FULL) ? BUSY : IDLE;
      end
      // The stale response is the only thing that can end DROP; a further
      // redirect while waiting just retargets the PC.
      DROP: if (imem_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      pc     <= PC_RESET;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_next;
      if (redirect) begin
        pc     <= redirect_pc;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (accept) pc <= pc + 32'd8;
        if (push)   wr_ptr <= wr_ptr + 1'b1;
        if (pop)    rd_ptr <= rd_ptr + 1'b1;
        count <= count_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]   <= pc;
      data_mem[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      ixu_inst     <= NOP_INST;
      slot1_inst   <= NOP_INST;
      bundle_pc    <= '0;
      bundle_valid <= 1'b0;
    end else if (!stall) begin
      if (byp) begin
        ixu_inst     <= imem_rdata[31:0];
        slot1_inst   <= imem_rdata[63:32];
        bundle_pc    <= pc;
        bundle_valid <= 1'b1;
      end else if (count != '0) begin
        ixu_inst     <= data_mem[rd_ptr][31:0];
        slot1_inst   <= data_mem[rd_ptr][63:32];
        bundle_pc    <= pc_mem[rd_ptr];
        bundle_valid <= 1'b1;
      end else begin
        ixu_inst     <= NOP_INST;
        slot1_inst   <= NOP_INST;
        bundle_pc    <= '0;
        bundle_valid <= 1'b0;
      end
    end
  end

  assign imem_req    = (state == BUSY);
  assign imem_addr   = pc;
  assign fetch_state = state;

endmodule

// File: tb/tb_vliw_fetch.sv
// Bench for vliw_fetch: directed fetch/redirect/reset scenarios plus a
// scoreboard of expected {pc, bundle} entries consumed as bundles are presented.
module tb_vliw_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_valid = 1'b0;
  logic [63:0] imem_rdata = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] ixu_inst;
  logic [31:0] slot1_inst;
  logic [31:0] bundle_pc;
  logic        bundle_valid;
  logic [1:0]  fetch_state;

  int          checks = 0;
  int          errors = 0;
  logic [95:0] exp_q[$];
  logic [31:0] exp_pc;
  logic        mon_stall, mon_skip;

  vliw_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .ixu_inst(ixu_inst),
    .slot1_inst(slot1_inst), .bundle_pc(bundle_pc),
    .bundle_valid(bundle_valid), .fetch_state(fetch_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_nop(input string tag);
    check(tag, {bundle_valid, slot1_inst, ixu_inst}, {1'b0, NOP, NOP});
  endtask

  task automatic respond(input logic [63:0] data);
    check("resp_req", imem_req, 1'b1);
    check("resp_addr", imem_addr, exp_pc);
    imem_valid = 1'b1;
    imem_rdata = data;
    exp_q.push_back({exp_pc, data});
    tick();
    imem_valid = 1'b0;
    exp_pc += 32'd8;
  endtask

  // Every edge that is not reset/redirect/stall reloads the output, so a
  // valid bundle there must be the next expected one.
  always @(posedge clk) begin
    mon_stall = stall;
    mon_skip  = rst || redirect;
    #2;
    if (!mon_skip && !mon_stall && bundle_valid) begin
      if (exp_q.size() == 0) check("sb_underflow", 96'(exp_q.size()), 96'd1);
      else check("sb_bundle", {bundle_pc, slot1_inst, ixu_inst}, exp_q.pop_front());
    end
  end

  initial begin
    tick(); tick();
    check("rst_req", imem_req, 1'b0);
    check("rst_addr", imem_addr, 32'h0);
    check_nop("rst_out");
    check("rst_pc", bundle_pc, 32'h0);
    check("rst_state", fetch_state, 2'd0);

    // Reset release and first fetch
    rst = 1'b0;
    exp_pc = 32'h0;
    tick();
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, 32'h0);
    tick(); tick();
    respond(64'h22222222_11111111);
`ifndef VLIW_FETCH_BYPASS_EN
    check("nobyp_latency", bundle_valid, 1'b0);
    tick();
`endif
    check("first_bundle", {bundle_valid, bundle_pc, slot1_inst, ixu_inst},
          {1'b1, 32'h0, 32'h22222222, 32'h11111111});
    check("second_addr", imem_addr, 32'h8);
    check("second_req", imem_req, 1'b1);

    // Empty FIFO gives NOP fill
    for (int i = 0; i < 5; i++) begin
      tick();
      check_nop("empty_fifo");
    end

    // Reset while BUSY
    check("pre_rst_state", fetch_state, 2'd1);
    rst = 1'b1;
    exp_q.delete();
    tick();
    check("mid_rst_req", imem_req, 1'b0);
    check("mid_rst_addr", imem_addr, 32'h0);
    check("mid_rst_state", fetch_state, 2'd0);
    check_nop("mid_rst_out");

    // Fill under stall with zero-latency responses
    stall = 1'b1;
    rst = 1'b0;
    exp_pc = 32'h0;
    tick();
    for (int i = 0; i < 4; i++) respond({$urandom(), $urandom()});
    check("full_req", imem_req, 1'b0);
    check("full_addr", imem_addr, 32'h20);
    check_nop("full_stalled_out");
    tick();
    check("full_hold_req", imem_req, 1'b0);
    stall = 1'b0;
    tick();
    check("req_after_pop", imem_req, 1'b1);
    check("pop_first", {bundle_valid, bundle_pc}, {1'b1, 32'h0});
    for (int i = 1; i < 4; i++) begin
      tick();
      check("pop_order", {bundle_valid, bundle_pc}, {1'b1, 32'(i * 8)});
    end
    tick();
    check_nop("after_drain");
    check("full_next_addr", imem_addr, 32'h20);

    // Redirect while BUSY with no response, then a stale response
    redirect = 1'b1;
    redirect_pc = 32'h100;
    exp_q.delete();
    tick();
    redirect = 1'b0;
    exp_pc = 32'h100;
    check("drop_state", fetch_state, 2'd2);
    check("drop_req", imem_req, 1'b0);
    check("redir_addr", imem_addr, 32'h100);
    check_nop("redir_out");
    tick();
    check_nop("drop_wait");
    tick();
    check_nop("drop_wait");
    imem_valid = 1'b1;
    imem_rdata = 64'hdeadbeef_deadbeef;
    tick();
    imem_valid = 1'b0;
    check("stale_state", fetch_state, 2'd0);
    check("stale_req", imem_req, 1'b0);
    check_nop("stale_out");
    tick();
    check("redir_req", imem_req, 1'b1);
    check("redir_fetch_addr", imem_addr, 32'h100);
    check_nop("stale_never");
    tick();
    respond(64'h44444444_33333333);
`ifndef VLIW_FETCH_BYPASS_EN
    check("redir_nobyp_latency", bundle_valid, 1'b0);
    tick();
`endif
    check("redir_bundle", {bundle_valid, bundle_pc, ixu_inst}, {1'b1, 32'h100, 32'h33333333});

    // Redirect + response + stall on the same edge
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'h200;
    imem_valid = 1'b1;
    imem_rdata = {$urandom(), $urandom()};
    exp_q.delete();
    tick();
    redirect = 1'b0;
    imem_valid = 1'b0;
    exp_pc = 32'h200;
    check("sim_state", fetch_state, 2'd0);
    check("sim_req", imem_req, 1'b0);
    check("sim_addr", imem_addr, 32'h200);
    check_nop("sim_out");
    tick();
    check("sim_refetch", {fetch_state, imem_req, imem_addr}, {2'd1, 1'b1, 32'h200});
    check_nop("sim_stalled_out");
    stall = 1'b0;

    // Random-latency stream through the scoreboard
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      respond({$urandom(), $urandom()});
    end
    repeat (4) tick();
    check("sb_drained", 96'(exp_q.size()), 96'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
